wqe_read_wrr_scheduler: RTL and testbench

Parametrised WQE-read scheduler that picks which active QP gets the next WQE fetch. It supports plain round-robin and weighted round-robin (per-QP burst weights). Output is a valid/ready handshake, held stable until accepted, instead of a one-cycle pulse. It sits between the per-QP doorbell/active tracker and the WQE fetch engine, gated by WQE-cache almost-full.

---
 rtl/wqe_read_wrr_scheduler.sv | 112 +++++++++++
 tb/tb_wqe_read_wrr_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/wqe_read_wrr_scheduler.sv
// WQE-read scheduler: picks the next active QP for a WQE fetch using plain or
// weighted round-robin, presenting the grant on a valid/ready handshake.
module wqe_read_wrr_scheduler #(
   parameter int MAX_QP       = 32,
   parameter int QP_PTR_WIDTH = 5,
   parameter int WEIGHT_WIDTH = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_mode,
   input  logic                           i_wqe_cache_alfull,
   input  logic [MAX_QP-1:0]              i_active,
   input  logic [MAX_QP*WEIGHT_WIDTH-1:0] i_weight,
   output logic                           o_sched_val,
   input  logic                           i_sched_rdy,
   output logic [QP_PTR_WIDTH-1:0]        o_qp_idx,
   output logic [MAX_QP-1:0]              o_qp_idx_one_hot
);

   typedef enum logic [1:0] {IDLE, ARB, HOLD} state_t;
   typedef logic [QP_PTR_WIDTH-1:0] qp_t;
   typedef logic [WEIGHT_WIDTH-1:0] weight_t;

   localparam qp_t     LAST_QP_RST = qp_t'(MAX_QP - 1);
   localparam weight_t W_ONE       = weight_t'(1);
   localparam weight_t BURST_MAX   = '1;

   state_t            state;
   qp_t               last_qp;
   weight_t           burst_cnt;
   logic              burst_inc;

   logic              hi_found, lo_found, last_active, burst_hold;
   qp_t               hi_idx, lo_idx, winner;
   weight_t           last_weight, eff_weight;
   logic [MAX_QP-1:0] winner_oh;

   // Round-robin scan split in two passes: QPs above last_qp win first, then
   // the wrap-around pass from 0 up to and including last_qp.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      hi_found    = 1'b0;
      lo_found    = 1'b0;
      hi_idx      = '0;
      lo_idx      = '0;
      last_active = 1'b0;
      last_weight = '0;
      for (int q = 0; q < MAX_QP; q++) begin
         if (qp_t'(q) == last_qp) begin
            last_active = i_active[q];
            last_weight = i_weight[q*WEIGHT_WIDTH +: WEIGHT_WIDTH];
         end
         if (i_active[q] && !hi_found && (qp_t'(q) > last_qp)) begin
            hi_found = 1'b1;
            hi_idx   = qp_t'(q);
         end
         if (i_active[q] && !lo_found && (qp_t'(q) <= last_qp)) begin
            lo_found = 1'b1;
            lo_idx   = qp_t'(q);
         end
      end
      eff_weight = (last_weight == '0) ? W_ONE : last_weight;
      burst_hold = i_mode && (burst_cnt != '0) && last_active && (burst_cnt < eff_weight);
      winner     = burst_hold ? last_qp : (hi_found ? hi_idx : lo_idx);
      winner_oh  = '0;
      for (int q = 0; q < MAX_QP; q++) begin
         winner_oh[q] = (qp_t'(q) == winner);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         last_qp          <= LAST_QP_RST;
         burst_cnt        <= '0;
         burst_inc        <= 1'b0;
         o_sched_val      <= 1'b0;
         o_qp_idx         <= '0;
         o_qp_idx_one_hot <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         case (state)
            IDLE: begin
               if (!i_wqe_cache_alfull && |i_active) state <= ARB;
            end
            ARB: begin
               if (|i_active) begin
                  o_qp_idx         <= winner;
                  o_qp_idx_one_hot <= winner_oh;
                  o_sched_val      <= 1'b1;
                  burst_inc        <= i_mode && (winner == last_qp);
                  state            <= HOLD;
               end else begin
                  state <= IDLE;
               end
            end
            HOLD: begin
               // Pointer and burst state move only once the fetch engine takes the grant.
               if (i_sched_rdy) begin
                  o_sched_val <= 1'b0;
                  last_qp     <= o_qp_idx;
                  if (!burst_inc)                  burst_cnt <= W_ONE;
                  else if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + W_ONE;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wqe_read_wrr_scheduler.sv
// Self-checking bench for wqe_read_wrr_scheduler: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_wqe_read_wrr_scheduler;

   localparam int MAX_QP = 32;
   localparam int PW     = 5;
   localparam int WW     = 4;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   mode = 1'b0;
   logic                   alfull = 1'b0;
   logic                   rdy = 1'b0;
   logic [MAX_QP-1:0]      active = '0;
   logic [MAX_QP*WW-1:0]   weight = '0;
   logic                   sched_val;
   logic [PW-1:0]          qp_idx;
   logic [MAX_QP-1:0]      qp_oh;

   wqe_read_wrr_scheduler #(.MAX_QP(MAX_QP), .QP_PTR_WIDTH(PW), .WEIGHT_WIDTH(WW)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .i_mode             (mode),
      .i_wqe_cache_alfull (alfull),
      .i_active           (active),
      .i_weight           (weight),
      .o_sched_val        (sched_val),
      .i_sched_rdy        (rdy),
      .o_qp_idx           (qp_idx),
      .o_qp_idx_one_hot   (qp_oh)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Reference model: phase 0 waiting to start, 1 arbitrating, 2 holding a grant.
   int                m_phase, m_last, m_burst, m_idx;
   bit                m_inc, m_val;
   logic [MAX_QP-1:0] m_oh;

   int grants[$];
   int grant_cyc[$];
   bit prev_val;

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int eff_w(int q);
      int w;
      w = int'(weight[q*WW +: WW]);
      return (w == 0) ? 1 : w;
   endfunction

   function automatic int pick();
      if (mode && m_burst != 0 && active[m_last] && m_burst < eff_w(m_last)) return m_last;
      for (int k = 1; k <= MAX_QP; k++) begin
         int q;
         q = (m_last + k) % MAX_QP;
         if (active[q]) return q;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_last = MAX_QP - 1; m_burst = 0; m_idx = 0;
      m_inc = 0; m_val = 0; m_oh = '0;
      prev_val = 0;
      grants.delete();
      grant_cyc.delete();
   endtask

   task automatic step();
      int w;
      @(posedge clk);
      cyc++;
      case (m_phase)
         0: if (!alfull && active != '0) m_phase = 1;
         1: begin
            w = pick();
            if (w >= 0) begin
               m_idx = w; m_oh = '0; m_oh[w] = 1'b1; m_val = 1;
               m_inc = mode && (w == m_last);
               m_phase = 2;
            end else begin
               m_phase = 0;
            end
         end
         default: if (rdy) begin
            m_val = 0;
            m_burst = m_inc ? ((m_burst < 15) ? m_burst + 1 : 15) : 1;
            m_last = m_idx;
            m_phase = 0;
         end
      endcase
      @(negedge clk);
      check("val", 64'(sched_val), 64'(m_val));
      check("idx", 64'(qp_idx), 64'(m_idx));
      check("onehot", 64'(qp_oh), 64'(m_oh));
      if (sched_val && !prev_val) begin
         grants.push_back(int'(qp_idx));
         grant_cyc.push_back(cyc);
      end
      prev_val = sched_val;
   endtask

   // Asynchronous reset asserted between clock edges.
   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      check("rst_val", 64'(sched_val), 64'd0);
      check("rst_idx", 64'(qp_idx), 64'd0);
      check("rst_oh", 64'(qp_oh), 64'd0);
      model_reset();
      #1 rst_n = 1'b1;
   endtask

   initial begin
      int exp_rr[5];
      int exp_wrr[8];
      int held, target, saved_last;
      exp_rr  = '{0, 1, 3, 0, 1};
      exp_wrr = '{0, 0, 0, 1, 0, 0, 0, 1};

      model_reset();
      #12;
      check("por_val", 64'(sched_val), 64'd0);
      check("por_idx", 64'(qp_idx), 64'd0);
      check("por_oh", 64'(qp_oh), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Plain round-robin over QPs 0, 1, 3
      mode = 0; active = 32'b1011; rdy = 1;
      repeat (15) step();
      check("rr_count", 64'(grants.size()), 64'd5);
      for (int i = 0; i < 5 && i < grants.size(); i++) check("rr_seq", 64'(grants[i]), 64'(exp_rr[i]));
      for (int i = 1; i < grant_cyc.size(); i++) check("rr_gap", 64'(grant_cyc[i] - grant_cyc[i-1]), 64'd3);
      active = '0;
      repeat (2) step();

      // Weighted round-robin: QP0 weight 3, QP1 weight 0 (treated as 1)
      async_reset();
      mode = 1; active = 32'b11; rdy = 1;
      weight = '0; weight[0 +: WW] = 4'd3; weight[WW +: WW] = 4'd0;
      repeat (25) step();
      check("wrr_count", 64'(grants.size()), 64'd8);
      for (int i = 0; i < 8 && i < grants.size(); i++) check("wrr_seq", 64'(grants[i]), 64'(exp_wrr[i]));
      active = '0;
      repeat (2) step();

      // Backpressure: grant frozen while rdy low, whatever i_active does
      mode = 0; rdy = 0; active = $urandom | 32'h1;
      repeat (2) step();
      check("bp_val", 64'(sched_val), 64'd1);
      held = int'(qp_idx);
      for (int i = 0; i < 10; i++) begin
         active = (i % 2 == 0) ? '0 : $urandom;
         step();
         check("bp_hold_val", 64'(sched_val), 64'd1);
         check("bp_hold_idx", 64'(qp_idx), 64'(held));
      end
      rdy = 1; active = '0;
      step();
      check("bp_accept", 64'(sched_val), 64'd0);
      check("bp_idx_kept", 64'(qp_idx), 64'(held));

      // Almost-full blocks leaving idle
      alfull = 1; active = '1;
      repeat (6) begin
         step();
         check("af_block", 64'(sched_val), 64'd0);
      end
      alfull = 0;
      step();
      check("af_arb", 64'(sched_val), 64'd0);
      step();
      check("af_grant", 64'(sched_val), 64'd1);
      active = '0;
      repeat (2) step();

      // Active drops during arbitration: no grant, pointer untouched
      saved_last = m_last;
      target = (saved_last + 5) % MAX_QP;
      active = '0; active[target] = 1'b1;
      step();
      active = '0;
      step();
      check("drop_val", 64'(sched_val), 64'd0);
      step();
      active = '1;
      repeat (2) step();
      check("drop_next", 64'(qp_idx), 64'((saved_last + 1) % MAX_QP));
      step();

      // Reset in the middle of a held grant
      rdy = 0; active = '1;
      repeat (3) step();
      async_reset();
      active = 32'h1; rdy = 1; mode = 0;
      repeat (2) step();
      check("post_rst_val", 64'(sched_val), 64'd1);
      check("post_rst_idx", 64'(qp_idx), 64'd0);
      check("post_rst_oh", 64'(qp_oh), 64'd1);
      step();

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 19) == 0) mode = ~mode;
         if ($urandom_range(0, 49) == 0) for (int q = 0; q < MAX_QP; q++) weight[q*WW +: WW] = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 3))
            0: active = '0;
            1: active = $urandom & $urandom & $urandom;
            2: active = 32'h1 << $urandom_range(0, MAX_QP - 1);
            default: active = $urandom;
         endcase
         alfull = ($urandom_range(0, 4) == 0);
         rdy    = ($urandom_range(0, 9) < 6);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
